// File: rtl/aska_npg_pulse_monitor.sv
// ---------------------------------------------------------------------------
// aska_npg_pulse_monitor
//   Receive-side checker for the ASKA NPG electrode switch bus. It decodes
//   each biphasic pulse (anode/cathode, phase-1, inter-phase gap and phase-2
//   lengths). It also measures the start-to-start period and the pulses per
//   ON train, and it flags malformed switch patterns.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   up_switches[3:0]           high-side switches, bit i = electrode i
//   down_switches[3:0]         low-side switches
//   pulse_valid                1-cycle strobe: pulse decoded; the fields
//                              anode/cathode/ph1_len/gap_len/ph2_len/
//                              balance_err update with it and then hold
//   period_valid, period       1-cycle strobe + start-to-start cycle count
//   train_end, pulse_count     1-cycle strobe + pulses in the finished train
//   err_valid, err_code        1-cycle strobe + abort cause
//                              (1 shoot-through, 2 bad pattern,
//                               3 gap timeout, 4 wrong phase-2 pair)
// ---------------------------------------------------------------------------
module aska_npg_pulse_monitor #(
  parameter int LEN_W     = 8,
  parameter int PERIOD_W  = 12,
  parameter int MAX_GAP   = 16,
  parameter int TRAIN_GAP = 2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          up_switches,
  input  logic [3:0]          down_switches,
  output logic                pulse_valid,
  output logic [1:0]          anode,
  output logic [1:0]          cathode,
  output logic [LEN_W-1:0]    ph1_len,
  output logic [LEN_W-1:0]    gap_len,
  output logic [LEN_W-1:0]    ph2_len,
  output logic                balance_err,
  output logic                period_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                train_end,
  output logic [9:0]          pulse_count,
  output logic                err_valid,
  output logic [2:0]          err_code
);

  typedef enum logic [1:0] {IDLE, PH1, GAP, PH2} state_t;

  localparam logic [LEN_W-1:0]    LEN_MAX = '1;
  localparam logic [PERIOD_W-1:0] PER_MAX = '1;
  localparam logic [LEN_W-1:0]    GAP_LIM = LEN_W'(MAX_GAP);
  localparam logic [PERIOD_W-1:0] TG_LIM  = PERIOD_W'(TRAIN_GAP);

  function automatic logic [1:0] enc(input logic [3:0] v);
    enc = v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  endfunction

  // Input register; all decoding works from the registered copy.
  logic [3:0] up_q, dn_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      up_q <= '0;
      dn_q <= '0;
    end else begin
      up_q <= up_switches;
      dn_q <= down_switches;
    end
  end

  // Per-cycle classification. A pair with a shared index is a short, so
  // rejecting shorts first leaves only pairs on different electrodes.
  logic       c_none, c_short, c_pair, c_other;
  logic [1:0] up_idx, dn_idx;
  logic [1:0] an_r, ca_r;
  logic       is_a, is_b;

  always_comb begin
    c_none  = (up_q == 4'd0) && (dn_q == 4'd0);
    c_short = |(up_q & dn_q);
    c_pair  = !c_short && $onehot(up_q) && $onehot(dn_q);
    c_other = !c_none && !c_short && !c_pair;
    up_idx  = enc(up_q);
    dn_idx  = enc(dn_q);
    is_a    = c_pair && (up_idx == an_r) && (dn_idx == ca_r);
    is_b    = c_pair && (up_idx == ca_r) && (dn_idx == an_r);
  end

  // FSM
  state_t           state, state_nx;
  logic [LEN_W-1:0] ph1_c, gap_c, ph2_c;
  logic             start, ph1_inc, gap_set, gap_inc, ph2_set, ph2_inc, done, err;
  logic [2:0]       code;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    ph1_inc  = 1'b0;
    gap_set  = 1'b0;
    gap_inc  = 1'b0;
    ph2_set  = 1'b0;
    ph2_inc  = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    code     = 3'd0;
    if (c_short) begin
      err = 1'b1; code = 3'd1; state_nx = IDLE;
    end else if (c_other) begin
      err = 1'b1; code = 3'd2; state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (c_pair) begin start = 1'b1; state_nx = PH1; end
        PH1: begin
          if (is_a)        ph1_inc = 1'b1;
          else if (c_none) begin gap_set = 1'b1; state_nx = GAP; end
          else if (is_b)   begin ph2_set = 1'b1; state_nx = PH2; end
          else             begin err = 1'b1; code = 3'd4; state_nx = IDLE; end
        end
        GAP: begin
          if (c_none) begin
            if (gap_c == GAP_LIM) begin err = 1'b1; code = 3'd3; state_nx = IDLE; end
            else                  gap_inc = 1'b1;
          end else if (is_b) begin
            ph2_set = 1'b1; state_nx = PH2;
          end else begin
            err = 1'b1; code = 3'd4; state_nx = IDLE;
          end
        end
        PH2: begin
          if (is_b)        ph2_inc = 1'b1;
          else if (c_none) begin done = 1'b1; state_nx = IDLE; end
          else             begin err = 1'b1; code = 3'd4; state_nx = IDLE; end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Pulse measurement counters (saturating)
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r  <= '0;
      ca_r  <= '0;
      ph1_c <= '0;
      gap_c <= '0;
      ph2_c <= '0;
    end else begin
      if (start) begin
        an_r  <= up_idx;
        ca_r  <= dn_idx;
        ph1_c <= LEN_W'(1);
        gap_c <= '0;
        ph2_c <= '0;
      end
      if (ph1_inc && ph1_c != LEN_MAX) ph1_c <= ph1_c + 1'b1;
      if (gap_set)                     gap_c <= LEN_W'(1);
      if (gap_inc && gap_c != LEN_MAX) gap_c <= gap_c + 1'b1;
      if (ph2_set)                     ph2_c <= LEN_W'(1);
      if (ph2_inc && ph2_c != LEN_MAX) ph2_c <= ph2_c + 1'b1;
    end
  end

  // Decode / error outputs: strobes last one cycle, data holds
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_valid <= 1'b0;
      anode       <= '0;
      cathode     <= '0;
      ph1_len     <= '0;
      gap_len     <= '0;
      ph2_len     <= '0;
      balance_err <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= '0;
    end else begin
      pulse_valid <= done;
      err_valid   <= err;
      if (done) begin
        anode       <= an_r;
        cathode     <= ca_r;
        ph1_len     <= ph1_c;
        gap_len     <= gap_c;
        ph2_len     <= ph2_c;
        balance_err <= (ph1_c != ph2_c);
      end
      if (err) err_code <= code;
    end
  end

  // Period and train tracking. A start in the same cycle as the train
  // timeout takes priority, so the train keeps running.
  logic                train_run;
  logic [PERIOD_W-1:0] per_cnt;
  logic [9:0]          pulse_cnt, pc_nx;

  always_comb pc_nx = (done && pulse_cnt != 10'h3ff) ? pulse_cnt + 10'd1 : pulse_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      train_run    <= 1'b0;
      per_cnt      <= '0;
      pulse_cnt    <= '0;
      period_valid <= 1'b0;
      period       <= '0;
      train_end    <= 1'b0;
      pulse_count  <= '0;
    end else begin
      period_valid <= 1'b0;
      train_end    <= 1'b0;
      pulse_cnt    <= pc_nx;
      if (start) begin
        if (train_run) begin
          period       <= per_cnt;
          period_valid <= 1'b1;
        end
        per_cnt   <= PERIOD_W'(1);
        train_run <= 1'b1;
      end else if (train_run) begin
        if (per_cnt == TG_LIM) begin
          train_end   <= 1'b1;
          pulse_count <= pc_nx;
          pulse_cnt   <= '0;
          train_run   <= 1'b0;
          per_cnt     <= '0;
        end else if (per_cnt != PER_MAX) begin
          per_cnt <= per_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aska_npg_pulse_monitor.sv
module tb_aska_npg_pulse_monitor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  up_switches = '0, down_switches = '0;
  logic        pulse_valid, balance_err, period_valid, train_end, err_valid;
  logic [1:0]  anode, cathode;
  logic [7:0]  ph1_len, gap_len, ph2_len;
  logic [11:0] period;
  logic [9:0]  pulse_count;
  logic [2:0]  err_code;

  aska_npg_pulse_monitor dut (
    .clk(clk), .reset(reset), .up_switches(up_switches), .down_switches(down_switches),
    .pulse_valid(pulse_valid), .anode(anode), .cathode(cathode), .ph1_len(ph1_len),
    .gap_len(gap_len), .ph2_len(ph2_len), .balance_err(balance_err),
    .period_valid(period_valid), .period(period), .train_end(train_end),
    .pulse_count(pulse_count), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // strobe monitor, sampled on the falling edge
  int pv_n = 0, err_n = 0, per_n = 0, per400_n = 0, te_n = 0;
  int last_period = 0, last_pc = 0;
  always @(negedge clk) begin
    if (pulse_valid) pv_n <= pv_n + 1;
    if (err_valid) err_n <= err_n + 1;
    if (period_valid) begin
      per_n <= per_n + 1;
      last_period <= int'(period);
      if (period == 12'd400) per400_n <= per400_n + 1;
    end
    if (train_end) begin
      te_n <= te_n + 1;
      last_pc <= int'(pulse_count);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // hold pins for n cycles; returns 1 time unit after the last rising edge
  task automatic drive(input logic [3:0] u, input logic [3:0] d, input int n);
    up_switches = u;
    down_switches = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'd0, 4'd0, 2);
    reset = 1'b0;
  endtask

  // pulse on electrodes an/ca: A for n1, NONE ng, B n2, then NONE tail
  task automatic pulse(input int an, input int ca, input int n1, input int ng,
                       input int n2, input int tail);
    logic [3:0] ua, ub;
    ua = 4'd1 << an;
    ub = 4'd1 << ca;
    if (n1 > 0) drive(ua, ub, n1);
    if (ng > 0) drive(4'd0, 4'd0, ng);
    if (n2 > 0) drive(ub, ua, n2);
    if (tail > 0) drive(4'd0, 4'd0, tail);
  endtask

  typedef struct {
    int an, ca, n1, ng, n2;
    int pv, p1, g, p2, bal;
    int er, code;
  } row_t;

  row_t rows[5];
  int pv0, err0, per0, te0;

  initial begin
    rows[0] = '{an:3, ca:0, n1:3,   ng:2,  n2:3, pv:1, p1:3,   g:2,  p2:3, bal:0, er:0, code:0};
    rows[1] = '{an:1, ca:2, n1:3,   ng:0,  n2:2, pv:1, p1:3,   g:0,  p2:2, bal:1, er:0, code:0};
    rows[2] = '{an:0, ca:3, n1:1,   ng:16, n2:1, pv:1, p1:1,   g:16, p2:1, bal:0, er:0, code:0};
    rows[3] = '{an:2, ca:1, n1:2,   ng:17, n2:0, pv:0, p1:0,   g:0,  p2:0, bal:0, er:1, code:3};
    rows[4] = '{an:3, ca:0, n1:300, ng:0,  n2:3, pv:1, p1:255, g:0,  p2:3, bal:1, er:0, code:0};

    do_reset();
    chk("rst pulse_valid", int'(pulse_valid), 0);
    chk("rst anode", int'(anode), 0);
    chk("rst ph1_len", int'(ph1_len), 0);
    chk("rst period", int'(period), 0);
    chk("rst err_code", int'(err_code), 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      pv0 = pv_n; err0 = err_n;
      pulse(rows[i].an, rows[i].ca, rows[i].n1, rows[i].ng, rows[i].n2, 20);
      chk($sformatf("row%0d pv", i), pv_n - pv0, rows[i].pv);
      chk($sformatf("row%0d err", i), err_n - err0, rows[i].er);
      if (rows[i].pv != 0) begin
        chk($sformatf("row%0d anode", i), int'(anode), rows[i].an);
        chk($sformatf("row%0d cathode", i), int'(cathode), rows[i].ca);
        chk($sformatf("row%0d ph1", i), int'(ph1_len), rows[i].p1);
        chk($sformatf("row%0d gap", i), int'(gap_len), rows[i].g);
        chk($sformatf("row%0d ph2", i), int'(ph2_len), rows[i].p2);
        chk($sformatf("row%0d bal", i), int'(balance_err), rows[i].bal);
      end
      if (rows[i].er != 0) chk($sformatf("row%0d code", i), int'(err_code), rows[i].code);
    end

    // gap timeout, then a normal pulse decodes
    do_reset();
    pv0 = pv_n;
    pulse(3, 0, 2, 17, 0, 3);
    chk("gto code", int'(err_code), 3);
    pulse(3, 0, 3, 2, 3, 5);
    chk("gto next pv", pv_n - pv0, 1);
    chk("gto next ph1", int'(ph1_len), 3);
    chk("gto next gap", int'(gap_len), 2);

    // shoot-through mid phase 1, exact strobe timing
    do_reset();
    pv0 = pv_n; err0 = err_n;
    drive(4'b1000, 4'b0001, 2);
    drive(4'b0001, 4'b0001, 1);
    drive(4'd0, 4'd0, 1);
    chk("short err_valid", int'(err_valid), 1);
    chk("short code", int'(err_code), 1);
    drive(4'd0, 4'd0, 1);
    chk("short strobe 1cyc", int'(err_valid), 0);
    drive(4'd0, 4'd0, 10);
    chk("short no pv", pv_n - pv0, 0);
    chk("short err cnt", err_n - err0, 1);

    // wrong phase-2 pair
    do_reset();
    drive(4'b1000, 4'b0001, 3);
    drive(4'b0010, 4'b0001, 1);
    drive(4'd0, 4'd0, 4);
    chk("wrong pair code", int'(err_code), 4);

    // bad pattern in idle
    do_reset();
    drive(4'b0011, 4'b0000, 1);
    drive(4'd0, 4'd0, 4);
    chk("other code", int'(err_code), 2);

    // reset during phase 2
    do_reset();
    pulse(3, 0, 3, 2, 3, 5);
    pv0 = pv_n;
    drive(4'b1000, 4'b0001, 3);
    drive(4'b0001, 4'b1000, 2);
    reset = 1'b1;
    drive(4'b0001, 4'b1000, 1);
    chk("midrst pulse_valid", int'(pulse_valid), 0);
    chk("midrst anode", int'(anode), 0);
    chk("midrst ph1", int'(ph1_len), 0);
    chk("midrst ph2", int'(ph2_len), 0);
    reset = 1'b0;
    drive(4'd0, 4'd0, 6);
    chk("midrst no pv", pv_n - pv0, 0);

    // train of 5 pulses, starts 400 apart
    do_reset();
    per0 = per_n; te0 = te_n;
    for (int k = 0; k < 5; k++) begin
      pulse(3, 0, 3, 2, 3, 392);
      per400_n = per400_n;
    end
    drive(4'd0, 4'd0, 2100);
    chk("train periods", per_n - per0, 4);
    chk("train period val", last_period, 400);
    chk("train ends", te_n - te0, 1);
    chk("train pulse_count", last_pc, 5);

    // start exactly at TRAIN_GAP wins over train end
    do_reset();
    per0 = per_n; te0 = te_n;
    pulse(1, 2, 3, 2, 3, 1992);
    pulse(1, 2, 3, 2, 3, 5);
    chk("tie no train_end", te_n - te0, 0);
    chk("tie period", last_period, 2000);
    drive(4'd0, 4'd0, 2100);
    chk("tie train_end", te_n - te0, 1);
    chk("tie pulse_count", last_pc, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
